// File: rtl/rnd_arbiter.sv
// -----------------------------------------------------------------------------
// rnd_arbiter
//
// Shares one fixed-latency rounder between two requesters: the add unit
// (requester 0) and the mul/div unit (requester 1). Requests are granted
// round-robin and issued to the rounder one per cycle. Each result is
// routed back to the requester that issued it, exactly LAT cycles later.
// The block also keeps sticky IEEE flags and runs a small trap sequencer.
//
// When a returned result raises an enabled trap, the block stops issuing
// and lets the remaining in-flight operations finish (DRAIN). It then
// holds the trap (TRAP) until the trap is acknowledged.
//
// Parameters
//   PW   width of the opaque rounder-input bundle carried per request
//   LAT  fixed rounder latency in cycles, from issue to result (1..7)
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   reqN_valid/ready         request handshake for requester N (0 or 1)
//   reqN_data, reqN_db       rounder-input bundle, precision (1 = double)
//   rnd_valid/data/db        issue strobe and payload to the rounder
//   rnd_res, rnd_ieee        rounder result and flags, LAT cycles after issue
//   rspN_valid               result strobe back to requester N
//   rsp_data, rsp_ieee       returned result and flags (shared, 0 when idle)
//   trap_en, trap_ack        per-flag trap enable; trap acknowledge
//   flags_clr, flags         clear / value of the sticky IEEE flags
//   trap, trap_cause         trap pending; enabled flags of the first trap
//   busy                     one or more operations are in flight
// -----------------------------------------------------------------------------
module rnd_arbiter #(
  parameter int PW  = 128,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [PW-1:0] req0_data,
  input  logic          req0_db,

  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [PW-1:0] req1_data,
  input  logic          req1_db,

  output logic          rnd_valid,
  output logic [PW-1:0] rnd_data,
  output logic          rnd_db,
  input  logic [63:0]   rnd_res,
  input  logic [4:0]    rnd_ieee,

  output logic          rsp0_valid,
  output logic          rsp1_valid,
  output logic [63:0]   rsp_data,
  output logic [4:0]    rsp_ieee,

  input  logic [4:0]    trap_en,
  input  logic          trap_ack,
  input  logic          flags_clr,
  output logic [4:0]    flags,
  output logic          trap,
  output logic [4:0]    trap_cause,
  output logic          busy
);

  // The count ranges over 0..LAT, which needs one more code than LAT.
  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    S_RUN,    // issues allowed
    S_DRAIN,  // trap seen, waiting for in-flight operations to return
    S_TRAP    // trap pending, waiting for trap_ack
  } state_t;

  state_t          state_q, state_d;
  logic            last_q;        // requester granted most recently
  logic            grant_valid;
  logic            grant_id;
  logic            issue;
  logic [LAT-1:0]  pipe_v_q;      // one valid bit per rounder stage
  logic [LAT-1:0]  pipe_id_q;     // requester tag per rounder stage
  logic            rsp_valid;
  logic            rsp_id;
  logic [CW-1:0]   count_q, count_d;
  logic [4:0]      flags_d;
  logic [4:0]      cause_d;
  logic            trap_hit;

  // ---------------------------------------------------------------------------
  // Round-robin grant. On a tie, the requester that was not granted last
  // wins. A single valid requester is always granted. grant_id is only
  // meaningful while grant_valid is high.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    grant_valid = req0_valid | req1_valid;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_q;
    end else begin
      grant_id = req1_valid;
    end
  end

  // Ready depends on valid and on the registered state only. No ready path
  // feeds back into a valid, so there is no combinational loop.
  assign issue      = grant_valid && (state_q == S_RUN);
  assign req0_ready = issue && !grant_id;
  assign req1_ready = issue &&  grant_id;

  // The rounder payload is forced to zero when nothing is issued, so idle
  // cycles do not show stale requester data downstream.
  assign rnd_valid = issue;
  assign rnd_data  = !issue ? '0   : (grant_id ? req1_data : req0_data);
  assign rnd_db    = !issue ? 1'b0 : (grant_id ? req1_db   : req0_db);

  // ---------------------------------------------------------------------------
  // Issue-tracking shift register. Stage 0 captures an issue. The last stage
  // lines up with the cycle in which the rounder presents that issue's result.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every stage samples the value its neighbour held before this edge.
    if (rst) begin
      pipe_v_q <= '0;
    end else begin
      pipe_v_q[0] <= issue;
      for (int i = 1; i < LAT; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
      end
    end
  end

  // NOTE: the tags are never reset. The valid bits alone decide whether a
  // stage holds anything, and a stale tag behind a cleared valid is harmless.
  always_ff @(posedge clk) begin
    pipe_id_q[0] <= grant_id;
    for (int i = 1; i < LAT; i++) begin
      pipe_id_q[i] <= pipe_id_q[i-1];
    end
  end

  assign rsp_valid  = pipe_v_q[LAT-1];
  assign rsp_id     = pipe_id_q[LAT-1];
  assign rsp0_valid = rsp_valid && !rsp_id;
  assign rsp1_valid = rsp_valid &&  rsp_id;
  assign rsp_data   = rsp_valid ? rnd_res  : '0;
  assign rsp_ieee   = rsp_valid ? rnd_ieee : '0;

  // ---------------------------------------------------------------------------
  // In-flight count. An issue and a response in the same cycle cancel out.
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    if (issue && !rsp_valid) begin
      count_d = count_q + CW'(1);
    end else if (!issue && rsp_valid) begin
      count_d = count_q - CW'(1);
    end
  end

  assign busy = (count_q != '0);

  // The clear is applied before the OR, so a response that coincides with a
  // clear still leaves its own flags set.
  assign flags_d = (flags_clr ? 5'b0 : flags) | rsp_ieee;

  // ---------------------------------------------------------------------------
  // Trap sequencer, next-state logic.
  //
  // The TRAP/DRAIN decision uses the count after this cycle. A trapping
  // result that is the last one outstanding therefore goes straight to
  // TRAP, without a DRAIN cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cause_d  = trap_cause;
    trap_hit = rsp_valid && ((rsp_ieee & trap_en) != 5'b0);
    unique case (state_q)
      S_RUN: begin
        if (trap_hit) begin
          cause_d = rsp_ieee & trap_en;
          state_d = (count_d == '0) ? S_TRAP : S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Later trapping results must not overwrite the first cause.
        if (count_d == '0) begin
          state_d = S_TRAP;
        end
      end
      S_TRAP: begin
        if (trap_ack) begin
          state_d = S_RUN;
          cause_d = 5'b0;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  assign trap = (state_q == S_TRAP);

  // ---------------------------------------------------------------------------
  // Control registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      last_q     <= 1'b1;   // requester 1 counts as "last", so 0 wins the first tie
      count_q    <= '0;
      flags      <= 5'b0;
      trap_cause <= 5'b0;
    end else begin
      state_q    <= state_d;
      if (issue) begin
        last_q <= grant_id;
      end
      count_q    <= count_d;
      flags      <= flags_d;
      trap_cause <= cause_d;
    end
  end

endmodule

// File: tb/tb_rnd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rnd_arbiter
//
// Self-checking bench for rnd_arbiter (PW = 128, LAT = 2).
//
// The driver (step task) applies one cycle of stimulus. It plays the
// rounder: it returns a result derived from the issued data, LAT cycles
// later. It also keeps a transaction-level reference model: the tie
// winner, drain/trap flags, sticky flags and trap cause. The number in
// flight is simply the number of outstanding scoreboard entries.
//
// On every issue the model pushes the expected response into the
// scoreboard queue. A separate monitor compares the DUT's outputs with
// the model each cycle. It pops an entry whenever the DUT presents a
// response.
// -----------------------------------------------------------------------------
module tb_rnd_arbiter;

  localparam int PW  = 128;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [PW-1:0] req0_data = '0, req1_data = '0;
  logic          req0_db = 1'b0, req1_db = 1'b0;
  logic          rnd_valid;
  logic [PW-1:0] rnd_data;
  logic          rnd_db;
  logic [63:0]   rnd_res = '0;
  logic [4:0]    rnd_ieee = '0;
  logic          rsp0_valid, rsp1_valid;
  logic [63:0]   rsp_data;
  logic [4:0]    rsp_ieee;
  logic [4:0]    trap_en = '0;
  logic          trap_ack = 1'b0, flags_clr = 1'b0;
  logic [4:0]    flags;
  logic          trap;
  logic [4:0]    trap_cause;
  logic          busy;

  rnd_arbiter #(.PW(PW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_db(req0_db),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_db(req1_db),
    .rnd_valid(rnd_valid), .rnd_data(rnd_data), .rnd_db(rnd_db),
    .rnd_res(rnd_res), .rnd_ieee(rnd_ieee),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data), .rsp_ieee(rsp_ieee),
    .trap_en(trap_en), .trap_ack(trap_ack), .flags_clr(flags_clr),
    .flags(flags), .trap(trap), .trap_cause(trap_cause), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v0, v1;
    logic [PW-1:0] d0, d1;
    bit          db0, db1;
    logic [4:0]  ten;
    bit          ack, clr, r;
    logic [4:0]  ret;    // flags the rounder returns for whatever issues this cycle
  } stim_t;

  typedef struct {
    bit          id;
    logic [63:0] res;
    logic [4:0]  ieee;
    int          due;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  // Reference model state.
  bit         m_last  = 1'b1;
  bit         m_drain = 1'b0;
  bit         m_trap  = 1'b0;
  logic [4:0] m_flags = '0;
  logic [4:0] m_cause = '0;

  // Expectations for the current cycle, published by the driver.
  bit            exp_rdy0, exp_rdy1, exp_iss, exp_db, exp_trap, exp_busy;
  logic [PW-1:0] exp_data;
  logic [4:0]    exp_flags, exp_cause;

  // DUT outputs sampled by the driver, used by the directed scenarios.
  bit obs_rdy0, obs_rdy1, obs_rsp0, obs_rsp1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] rand_data();
    logic [PW-1:0] d;
    for (int i = 0; i < PW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic stim_t idle_stim(input logic [4:0] ten);
    stim_t s;
    s.v0 = 0; s.v1 = 0; s.d0 = rand_data(); s.d1 = rand_data();
    s.db0 = 1'($urandom); s.db1 = 1'($urandom);
    s.ten = ten; s.ack = 0; s.clr = 0; s.r = 0; s.ret = '0;
    return s;
  endfunction

  // One clock cycle of stimulus plus the reference-model update.
  task automatic step(input stim_t s);
    bit            gid, iss, resp;
    int            cnt_after;
    logic [4:0]    ri;
    logic [PW-1:0] gd;
    exp_t          e;
    @(negedge clk);
    rst = s.r; req0_valid = s.v0; req1_valid = s.v1;
    req0_data = s.d0; req1_data = s.d1; req0_db = s.db0; req1_db = s.db1;
    trap_en = s.ten; trap_ack = s.ack; flags_clr = s.clr;
    resp = (sb.size() != 0) && (sb[0].due == cyc);
    if (resp) begin
      rnd_res = sb[0].res; rnd_ieee = sb[0].ieee; ri = sb[0].ieee;
    end else begin
      rnd_res = {$urandom, $urandom}; rnd_ieee = 5'($urandom); ri = '0;
    end
    gid = (s.v0 && s.v1) ? !m_last : s.v1;
    iss = (s.v0 || s.v1) && !m_drain && !m_trap;
    gd  = gid ? s.d1 : s.d0;
    exp_rdy0 = iss && !gid;  exp_rdy1 = iss && gid;  exp_iss = iss;
    exp_data = gd;           exp_db = gid ? s.db1 : s.db0;
    exp_flags = m_flags;     exp_trap = m_trap;      exp_cause = m_cause;
    exp_busy  = (sb.size() != 0);
    cnt_after = sb.size() + int'(iss) - int'(resp);
    if (iss) begin
      e.id = gid; e.res = gd[63:0] ^ gd[PW-1:PW-64]; e.ieee = s.ret; e.due = cyc + LAT;
      sb.push_back(e);
    end
    #3;
    obs_rdy0 = req0_ready; obs_rdy1 = req1_ready;
    obs_rsp0 = rsp0_valid; obs_rsp1 = rsp1_valid;
    @(posedge clk);
    if (s.r) begin
      sb.delete();
      m_last = 1'b1; m_drain = 0; m_trap = 0; m_flags = '0; m_cause = '0;
    end else begin
      if (iss) m_last = gid;
      m_flags = (s.clr ? 5'b0 : m_flags) | ri;
      if (!m_drain && !m_trap) begin
        if (resp && ((ri & s.ten) != 0)) begin
          m_cause = ri & s.ten;
          if (cnt_after == 0) m_trap = 1; else m_drain = 1;
        end
      end else if (m_drain) begin
        if (cnt_after == 0) begin m_drain = 0; m_trap = 1; end
      end else if (s.ack) begin
        m_trap = 0; m_cause = '0;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    stim_t s;
    s = idle_stim('0); s.r = 1;
    step(s); step(s);
  endtask

  // Monitor: compares every cycle, popping the scoreboard on each response.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      #2;
      check("req0_ready", req0_ready, exp_rdy0);
      check("req1_ready", req1_ready, exp_rdy1);
      check("rnd_valid", rnd_valid, exp_iss);
      if (exp_iss) begin
        check("rnd_data", rnd_data, exp_data);
        check("rnd_db", rnd_db, exp_db);
      end
      check("flags", flags, exp_flags);
      check("trap", trap, exp_trap);
      check("trap_cause", trap_cause, exp_cause);
      check("busy", busy, exp_busy);
      if (rsp0_valid || rsp1_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", {rsp1_valid, rsp0_valid}, 2'b00);
        end else begin
          e = sb.pop_front();
          check("rsp_id", {rsp1_valid, rsp0_valid}, e.id ? 2'b10 : 2'b01);
          check("rsp_cycle", cyc, e.due);
          check("rsp_data", rsp_data, e.res);
          check("rsp_ieee", rsp_ieee, e.ieee);
        end
      end else begin
        check("rsp_data_idle", rsp_data, 64'h0);
        check("rsp_ieee_idle", rsp_ieee, 5'h0);
        if (sb.size() != 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          check("rsp_missing", {rsp1_valid, rsp0_valid}, e.id ? 2'b10 : 2'b01);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    bit g0[6], g1[6], r0[6], r1[6];

    step(idle_stim('0) );
    do_reset();
    mon_en = 1'b1;
    do_reset();
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_flags", flags, 5'b0);
    check("reset_trap", trap, 1'b0);
    check("reset_rsp_data", rsp_data, 64'h0);

    // Both requesters valid for four cycles: grants and responses alternate.
    for (int i = 0; i < 6; i++) begin
      s = idle_stim('0); s.v0 = (i < 4); s.v1 = (i < 4);
      step(s);
      g0[i] = obs_rdy0; g1[i] = obs_rdy1; r0[i] = obs_rsp0; r1[i] = obs_rsp1;
    end
    for (int i = 0; i < 4; i++) begin
      check("rr_grant0", g0[i], (i % 2) == 0);
      check("rr_grant1", g1[i], (i % 2) == 1);
    end
    for (int i = 0; i < 6; i++) begin
      check("rr_rsp0", r0[i], (i >= 2) && ((i - 2) % 2 == 0));
      check("rr_rsp1", r1[i], (i >= 2) && ((i - 2) % 2 == 1));
    end

    // Sticky flags without trap; a clear coinciding with a response keeps its flags.
    do_reset();
    s = idle_stim('0); s.v0 = 1; s.ret = 5'b10000; step(s);
    step(idle_stim('0)); step(idle_stim('0));
    #1;
    check("sticky_flags", flags, 5'b10000);
    check("sticky_no_trap", trap, 1'b0);
    s = idle_stim('0); s.v1 = 1; s.ret = 5'b00100; step(s);
    step(idle_stim('0));
    s = idle_stim('0); s.clr = 1; step(s);
    #1;
    check("clr_vs_rsp_flags", flags, 5'b00100);

    // Trap with another op in flight: DRAIN, then TRAP, then acknowledge.
    do_reset();
    s = idle_stim(5'b00100); s.v0 = 1; s.ret = 5'b00100; step(s);
    s = idle_stim(5'b00100); s.v1 = 1; s.ret = 5'b00000; step(s);
    step(idle_stim(5'b00100));
    s = idle_stim(5'b00100); s.v0 = 1; s.v1 = 1; step(s);
    check("drain_rdy0", obs_rdy0, 1'b0);
    check("drain_rdy1", obs_rdy1, 1'b0);
    check("drain_rsp_b", obs_rsp1, 1'b1);
    #1;
    check("drain_trap", trap, 1'b1);
    check("drain_cause", trap_cause, 5'b00100);
    s = idle_stim(5'b00100); s.ack = 1; step(s);
    #1;
    check("ack_trap", trap, 1'b0);
    check("ack_cause", trap_cause, 5'b00000);

    // Lone trapping result goes straight to TRAP; ack while in RUN is ignored.
    do_reset();
    s = idle_stim(5'b00001); s.v0 = 1; s.ret = 5'b00001; step(s);
    step(idle_stim(5'b00001));
    s = idle_stim(5'b00001); s.ack = 1; step(s);
    #1;
    check("direct_trap", trap, 1'b1);
    check("direct_cause", trap_cause, 5'b00001);
    s = idle_stim('0); s.ack = 1; step(s);

    // Reset one cycle after an issue drops the in-flight response.
    do_reset();
    s = idle_stim('0); s.v0 = 1; s.ret = 5'b11111; step(s);
    s = idle_stim('0); s.r = 1; step(s);
    step(idle_stim('0));
    check("rst_drop_rsp", {obs_rsp1, obs_rsp0}, 2'b00);
    #1;
    check("rst_drop_busy", busy, 1'b0);
    check("rst_drop_flags", flags, 5'b0);

    // Issue every cycle: count steady at LAT, busy stays high.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      s = idle_stim('0); s.v0 = 1; step(s);
      #1;
      check("steady_busy", busy, 1'b1);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      s = idle_stim(($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0);
      s.v0  = ($urandom_range(0, 2) != 0);
      s.v1  = ($urandom_range(0, 2) != 0);
      s.ret = 5'($urandom);
      s.ack = ($urandom_range(0, 3) == 0);
      s.clr = ($urandom_range(0, 7) == 0);
      s.r   = ($urandom_range(0, 63) == 0);
      step(s);
    end
    for (int i = 0; i < LAT + 3; i++) begin
      s = idle_stim('0); s.ack = 1; step(s);
    end

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
